// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer with one-shot/periodic modes and a maskable interrupt.
module timer_dev #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] DIN,
    output logic [31:0] DOUT,
    output logic        IRQ
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    state_t state, state_nx;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    logic        hit, wr_ctrl, wr_preset, en, periodic, zero;
    logic        unused_addr;
    assign unused_addr = ^Addr[1:0];
    assign hit       = Addr[31:4] == BASE[31:4];
    assign wr_ctrl   = WE && hit && Addr[3:2] == 2'd0;
    assign wr_preset = WE && hit && Addr[3:2] == 2'd1;
    assign en        = ctrl[0];
    assign periodic  = ctrl[2:1] == 2'b01;
    assign zero      = count == 32'd0;
    always_comb begin
        state_nx = (state == IDLE) ? (en ? LOAD : IDLE) :
                   (state == LOAD) ? CNT :
                   (state == CNT)  ? (!en ? IDLE : zero ? INT : CNT) :
                                     (periodic ? LOAD : IDLE);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            state <= state_nx;
            // a CTRL write on the one-shot INT edge keeps the written En
            if (wr_ctrl)
                ctrl <= DIN[3:0];
            else if (state == INT && !periodic)
                ctrl[0] <= 1'b0;
            if (wr_preset)
                preset <= DIN;
            if (state == LOAD)
                count <= preset;
            else if (state == CNT && en && !zero)
                count <= count - 32'd1;
            if (wr_ctrl)
                irq_flag <= 1'b0;
            else if (state == CNT && en && zero)
                irq_flag <= 1'b1;
            else if (state == INT && periodic)
                irq_flag <= 1'b0;
        end
    end
    assign DOUT = (Addr[3:2] == 2'd0) ? {28'd0, ctrl} :
                  (Addr[3:2] == 2'd1) ? preset :
                  (Addr[3:2] == 2'd2) ? count : 32'd0;
    assign IRQ = ctrl[3] & irq_flag;
endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed self-checking bench for timer_dev.
module tb_timer_dev;
    localparam logic [31:0] B = 32'h0000_7F00;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] DIN;
    logic [31:0] DOUT;
    logic        IRQ;
    int          vecs = 0;
    int          errs = 0;
    logic [31:0] d;

    timer_dev #(.BASE(B)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .DIN(DIN), .DOUT(DOUT), .IRQ(IRQ)
    );

    always #10 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        Addr = a;
        DIN  = v;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        Addr = a;
        #1;
        v = DOUT;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        WE    = 1'b0;
        Addr  = B;
        DIN   = 32'd0;
        #2;
        for (int i = 0; i < 3; i++) begin
            rd(B + 32'(4 * i), d);
            vecs++;
            if (d !== 32'd0) begin errs++; $display("FAIL reset_reg off=%0d got %h exp 0", 4 * i, d); end
        end
        vecs++;
        if (IRQ !== 1'b0) begin errs++; $display("FAIL reset_irq got %b exp 0", IRQ); end
        @(negedge clk);
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_oneshot();
        wr(B + 4, 32'd3);
        wr(B, 32'h9);
        cyc();
        for (int k = 0; k < 4; k++) begin
            cyc();
            rd(B + 8, d);
            vecs++;
            if (d !== 32'(3 - k) || IRQ !== 1'b0) begin
                errs++; $display("FAIL oneshot_count k=%0d got %0d irq %b exp %0d irq 0", k, d, IRQ, 3 - k);
            end
        end
        cyc();
        vecs++;
        if (IRQ !== 1'b1) begin errs++; $display("FAIL oneshot_irq_rise got %b exp 1", IRQ); end
        repeat (3) cyc();
        rd(B, d);
        vecs++;
        if (IRQ !== 1'b1 || d !== 32'h8) begin errs++; $display("FAIL oneshot_hold irq %b ctrl %h exp 1 8", IRQ, d); end
        wr(B, 32'h8);
        rd(B, d);
        vecs++;
        if (IRQ !== 1'b0 || d !== 32'h8) begin errs++; $display("FAIL oneshot_clear irq %b ctrl %h exp 0 8", IRQ, d); end
    endtask

    task automatic test_periodic();
        logic [31:0] e;
        wr(B + 4, 32'd2);
        wr(B, 32'hB);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            vecs++;
            if (IRQ !== (i >= 5 && i % 5 == 0)) begin
                errs++; $display("FAIL periodic_irq cyc=%0d got %b exp %b", i, IRQ, (i >= 5 && i % 5 == 0));
            end
        end
        wr(B, 32'h3);
        for (int j = 1; j <= 10; j++) begin
            cyc();
            rd(B + 8, d);
            e = (j % 5 == 1) ? 32'd2 : (j % 5 == 2) ? 32'd1 : 32'd0;
            vecs++;
            if (IRQ !== 1'b0 || d !== e) begin
                errs++; $display("FAIL periodic_masked j=%0d irq %b count %0d exp 0 %0d", j, IRQ, d, e);
            end
        end
        wr(B, 32'h0);
        repeat (4) cyc();
    endtask

    task automatic test_disable();
        wr(B + 4, 32'd10);
        wr(B, 32'h9);
        repeat (6) cyc();
        rd(B + 8, d);
        vecs++;
        if (d !== 32'd6) begin errs++; $display("FAIL disable_pre got %0d exp 6", d); end
        wr(B, 32'h8);
        rd(B + 8, d);
        vecs++;
        if (d !== 32'd5) begin errs++; $display("FAIL disable_edge got %0d exp 5", d); end
        repeat (4) cyc();
        rd(B + 8, d);
        vecs++;
        if (d !== 32'd5 || IRQ !== 1'b0) begin errs++; $display("FAIL disable_frozen count %0d irq %b exp 5 0", d, IRQ); end
        wr(B, 32'h9);
        cyc();
        rd(B + 8, d);
        vecs++;
        if (d !== 32'd5) begin errs++; $display("FAIL reenable_load got %0d exp 5", d); end
        cyc();
        rd(B + 8, d);
        vecs++;
        if (d !== 32'd10) begin errs++; $display("FAIL reenable_reload got %0d exp 10", d); end
        wr(B, 32'h8);
        cyc();
    endtask

    task automatic test_edges();
        wr(B + 4, 32'd0);
        wr(B, 32'h9);
        cyc();
        cyc();
        vecs++;
        if (IRQ !== 1'b0) begin errs++; $display("FAIL zero_preset_early got %b exp 0", IRQ); end
        cyc();
        vecs++;
        if (IRQ !== 1'b1) begin errs++; $display("FAIL zero_preset_irq got %b exp 1", IRQ); end
        wr(B, 32'h8);
        wr(B + 8, 32'h1234);
        rd(B + 8, d);
        vecs++;
        if (d !== 32'd0) begin errs++; $display("FAIL count_ro got %h exp 0", d); end
        wr(B + 12, 32'hFFFF_FFFF);
        rd(B + 12, d);
        vecs++;
        if (d !== 32'd0) begin errs++; $display("FAIL off_c got %h exp 0", d); end
        rd(B + 4, d);
        vecs++;
        if (d !== 32'd0) begin errs++; $display("FAIL off_c_preset got %h exp 0", d); end
        wr(B + 32'h10, 32'hF);
        rd(B, d);
        vecs++;
        if (d !== 32'h8) begin errs++; $display("FAIL miss_ctrl got %h exp 8", d); end
        wr(B + 32'h14, 32'h55);
        rd(B + 4, d);
        vecs++;
        if (d !== 32'd0) begin errs++; $display("FAIL miss_preset got %h exp 0", d); end
        wr(B + 4, 32'd7);
        rd(32'h4, d);
        vecs++;
        if (d !== 32'd7) begin errs++; $display("FAIL nohit_read got %h exp 7", d); end
    endtask

    task automatic test_collision();
        wr(B + 4, 32'd1);
        wr(B, 32'h9);
        repeat (4) cyc();
        vecs++;
        if (IRQ !== 1'b1) begin errs++; $display("FAIL coll_int got %b exp 1", IRQ); end
        wr(B, 32'h9);
        rd(B, d);
        vecs++;
        if (d !== 32'h9 || IRQ !== 1'b0) begin errs++; $display("FAIL coll_write ctrl %h irq %b exp 9 0", d, IRQ); end
        cyc();
        cyc();
        rd(B + 8, d);
        vecs++;
        if (d !== 32'd1) begin errs++; $display("FAIL coll_restart got %0d exp 1", d); end
        wr(B, 32'h8);
        repeat (2) cyc();
    endtask

    task automatic test_reset_mid();
        wr(B + 4, 32'd10);
        wr(B, 32'h9);
        repeat (4) cyc();
        rd(B + 8, d);
        vecs++;
        if (d !== 32'd8) begin errs++; $display("FAIL rst_mid_pre got %0d exp 8", d); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vecs++;
        if (IRQ !== 1'b0) begin errs++; $display("FAIL rst_mid_irq got %b exp 0", IRQ); end
        for (int i = 0; i < 3; i++) begin
            rd(B + 32'(4 * i), d);
            vecs++;
            if (d !== 32'd0) begin errs++; $display("FAIL rst_mid_reg off=%0d got %h exp 0", 4 * i, d); end
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) cyc();
        rd(B + 8, d);
        vecs++;
        if (d !== 32'd0) begin errs++; $display("FAIL rst_release_count got %0d exp 0", d); end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_disable();
        test_edges();
        test_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
